// File: rtl/mmio_periph_bus_pkg.sv
// Address map and status-bit layout shared by the MMIO peripheral page.
package mmio_periph_bus_pkg;

  typedef logic [7:0] ioAddr_t;

  localparam ioAddr_t ADDR_LED      = 8'h00;
  localparam ioAddr_t ADDR_IN_STAT  = 8'h04;
  localparam ioAddr_t ADDR_IN_DATA  = 8'h08;
  localparam ioAddr_t ADDR_OUT_DATA = 8'h0C;
  localparam ioAddr_t ADDR_OUT_RDY  = 8'h10;
  localparam ioAddr_t ADDR_CYCLE    = 8'h14;
  localparam ioAddr_t ADDR_SW       = 8'h18;

  localparam int STAT_VALID_BIT   = 0;
  localparam int STAT_OVERRUN_BIT = 1;
  localparam int RDY_BIT          = 0;

endpackage

// File: rtl/mmio_periph_bus_btn_debounce.sv
// Two-flop synchronizer plus hold-time debounce for the push button;
// emits a one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    btnSync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stablePrev_q;
  logic          synced;

  assign synced = btnSync_q[1];

  // The counter only runs while the synchronized level disagrees with the
  // accepted level; any agreeing sample restarts the hold window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (synced != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnSync_q    <= '0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stablePrev_q <= 1'b0;
    end else begin
      btnSync_q    <= {btnSync_q[0], btn_i};
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stablePrev_q <= stable_q;
    end
  end

  assign press_o = stable_q & ~stablePrev_q;

endmodule

// File: rtl/mmio_periph_bus.sv
// MMIO slave behind the CPU MEM-stage IO port: LEDs, debounced switch
// capture channel, display handshake channel and a free-running cycle counter.
module mmio_periph_bus
  import mmio_periph_bus_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SW_W            = 16,
  parameter int LED_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       io_addr,
  input  logic [31:0]      io_dout,
  input  logic             io_we,
  input  logic             io_rd,
  output logic [31:0]      io_din,
  input  logic [SW_W-1:0]  sw,
  input  logic             btn,
  output logic [LED_W-1:0] led,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ack
);

  logic [SW_W-1:0]  swMeta_q, swSync_q;
  logic [LED_W-1:0] led_q, led_d;
  logic             inValid_q, inValid_d;
  logic             overrun_q, overrun_d;
  logic [SW_W-1:0]  inData_q, inData_d;
  logic [31:0]      outData_q, outData_d;
  logic             outValid_q, outValid_d;
  logic [31:0]      cycleCnt_q, cycleCnt_d;
  logic             press;
  logic             consume;
  logic             outAccept;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn),
    .press_o(press)
  );

  assign consume   = io_rd && (io_addr == ADDR_IN_DATA);
  assign outAccept = io_we && (io_addr == ADDR_OUT_DATA) && (!outValid_q || out_ack);

  always_comb begin
    led_d      = led_q;
    inValid_d  = inValid_q;
    overrun_d  = overrun_q;
    inData_d   = inData_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    cycleCnt_d = cycleCnt_q + 32'd1;

    if (io_we && (io_addr == ADDR_LED)) begin
      led_d = io_dout[LED_W-1:0];
    end

    // A consume frees the slot, so a press landing in the same cycle is
    // captured as fresh data rather than flagged as an overrun.
    if (consume) begin
      inValid_d = 1'b0;
      overrun_d = 1'b0;
    end
    if (press) begin
      if (!inValid_q || consume) begin
        inData_d  = swSync_q;
        inValid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (outAccept) begin
      outData_d  = io_dout;
      outValid_d = 1'b1;
    end else if (out_ack) begin
      outValid_d = 1'b0;
    end

    if (io_we && (io_addr == ADDR_CYCLE)) begin
      cycleCnt_d = io_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swMeta_q   <= '0;
      swSync_q   <= '0;
      led_q      <= '0;
      inValid_q  <= 1'b0;
      overrun_q  <= 1'b0;
      inData_q   <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      cycleCnt_q <= '0;
    end else begin
      swMeta_q   <= sw;
      swSync_q   <= swMeta_q;
      led_q      <= led_d;
      inValid_q  <= inValid_d;
      overrun_q  <= overrun_d;
      inData_q   <= inData_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      cycleCnt_q <= cycleCnt_d;
    end
  end

  always_comb begin
    io_din = '0;
    case (io_addr)
      ADDR_LED:     io_din = 32'(led_q);
      ADDR_IN_STAT: begin
        io_din[STAT_VALID_BIT]   = inValid_q;
        io_din[STAT_OVERRUN_BIT] = overrun_q;
      end
      ADDR_IN_DATA: io_din = 32'(inData_q);
      ADDR_OUT_RDY: io_din[RDY_BIT] = ~outValid_q;
      ADDR_CYCLE:   io_din = cycleCnt_q;
      ADDR_SW:      io_din = 32'(swSync_q);
      default:      io_din = '0;
    endcase
  end

  assign led       = led_q;
  assign out_data  = outData_q;
  assign out_valid = outValid_q;

endmodule
